// File: rtl/color_arb_pkg.sv
// Shared constants, FSM state type and reference reciprocal for the colour-map arbiter.
package color_arb_pkg;

    localparam int unsigned DEPTH_W     = 10;
    localparam int unsigned COLOR_W     = 24;
    localparam int unsigned RECIP_W_DEF = 16;
    localparam int unsigned QUOT_W      = 16;
    localparam int unsigned DVD_W       = 17;
    localparam int unsigned DIV_STEPS   = 17;
    localparam int unsigned CNT_W       = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } arb_state_t;

    // floor(65536/m), 0 for m == 0, saturated to 16 bits for m == 1
    function automatic logic [QUOT_W-1:0] recip_sat(input logic [DEPTH_W-1:0] m);
        logic [DVD_W-1:0] q;
        if (m == '0) begin
            return '0;
        end
        q = DVD_W'(17'h10000 / {7'b0, m});
        return q[DVD_W-1] ? 16'hFFFF : q[QUOT_W-1:0];
    endfunction

endpackage

// File: rtl/recip_divider.sv
// Restoring divider computing 2^16 / divisor over 17 cycles, with 0 and saturation handling.
module recip_divider
    import color_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [DEPTH_W-1:0] divisor,
    output logic               done_c,
    output logic [QUOT_W-1:0]  quot_c
);

    logic               active;
    logic [CNT_W-1:0]   cnt;
    logic [DVD_W-1:0]   dvd;
    logic [DEPTH_W-1:0] dvs;
    logic [DEPTH_W-1:0] rem;
    logic [DVD_W-1:0]   quo;

    logic [DEPTH_W:0]   rem_sh;
    logic               fits;
    logic [DEPTH_W-1:0] rem_nx;
    logic [DVD_W-1:0]   quo_nx;

    // One restoring step; the final step's quotient is presented directly on done_c
    always_comb begin
        rem_sh = {rem, dvd[DVD_W-1]};
        fits   = rem_sh >= {1'b0, dvs};
        rem_nx = fits ? DEPTH_W'(rem_sh - {1'b0, dvs}) : DEPTH_W'(rem_sh);
        quo_nx = {quo[DVD_W-2:0], fits};
        done_c = active && (cnt == CNT_W'(DIV_STEPS - 1));
        if (dvs == '0) begin
            quot_c = '0;
        end else if (quo_nx[DVD_W-1]) begin
            quot_c = '1;
        end else begin
            quot_c = quo_nx[QUOT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            cnt    <= '0;
            dvd    <= '0;
            dvs    <= '0;
            rem    <= '0;
            quo    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
            dvd    <= DVD_W'(17'h10000);
            dvs    <= divisor;
            rem    <= '0;
            quo    <= '0;
        end else if (active) begin
            dvd    <= {dvd[DVD_W-2:0], 1'b0};
            rem    <= rem_nx;
            quo    <= quo_nx;
            cnt    <= cnt + CNT_W'(1);
            if (done_c) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/color_map_arbiter.sv
// Round-robin sharing of one colour mapper between engines; owns the max_iter reciprocal.
// Optional COLOR_ARB_STATS_EN adds issue/stall counters.
module color_map_arbiter
    import color_arb_pkg::*;
#(
    parameter int unsigned NUM_ENGINES = 4,
    parameter int unsigned ID_W        = $clog2(NUM_ENGINES),
    parameter int unsigned RECIP_W     = RECIP_W_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [DEPTH_W-1:0]             max_iterations,
    input  logic [NUM_ENGINES-1:0]         req_valid,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] req_depth,
    output logic [NUM_ENGINES-1:0]         req_ready,
    output logic                           map_en,
    output logic [DEPTH_W-1:0]             map_depth,
    output logic [DEPTH_W-1:0]             map_max_iter,
    output logic [RECIP_W-1:0]             map_recip,
    input  logic                           map_valid,
    input  logic [COLOR_W-1:0]             map_color,
    output logic                           out_valid,
    output logic [COLOR_W-1:0]             out_color,
    output logic [ID_W-1:0]                out_engine,
`ifdef COLOR_ARB_STATS_EN
    output logic [31:0]                    stat_issued,
    output logic [31:0]                    stat_stall,
`endif
    output logic                           busy
);

    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_CALC = 1'(CALC);

    logic [0:0]         state, state_d;
    logic               init_q, init_d;
    logic [ID_W-1:0]    ptr, ptr_d;
    logic [ID_W-1:0]    tag, tag_d;
    logic               tag_live;
    logic [DEPTH_W-1:0] max_iter_d;
    logic [RECIP_W-1:0] recip_d;

    logic               found;
    logic [ID_W-1:0]    gnt;
    logic [DEPTH_W-1:0] gnt_depth;
    logic               div_start;
    logic               div_done;
    logic [QUOT_W-1:0]  div_quot;

    recip_divider u_div (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .divisor (max_iterations),
        .done_c  (div_done),
        .quot_c  (div_quot)
    );

    // First valid requester at or after the pointer, wrapping
    always_comb begin
        int unsigned idx;
        found     = 1'b0;
        gnt       = '0;
        gnt_depth = '0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            idx = (32'(ptr) + k) % NUM_ENGINES;
            if (!found && req_valid[ID_W'(idx)]) begin
                found = 1'b1;
                gnt   = ID_W'(idx);
            end
        end
        for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
            if (gnt == ID_W'(i)) begin
                gnt_depth = req_depth[DEPTH_W*i +: DEPTH_W];
            end
        end
    end

    always_comb begin
        state_d    = state;
        init_d     = init_q;
        ptr_d      = ptr;
        tag_d      = tag;
        max_iter_d = map_max_iter;
        recip_d    = map_recip;
        req_ready  = '0;
        map_en     = 1'b0;
        map_depth  = '0;
        busy       = 1'b1;
        div_start  = 1'b0;
        if (!reset) begin
            case (state)
                S_IDLE: begin
                    // init_q forces one recompute after every reset
                    if (init_q || (max_iterations != map_max_iter)) begin
                        max_iter_d = max_iterations;
                        init_d     = 1'b0;
                        div_start  = 1'b1;
                        state_d    = S_CALC;
                    end else begin
                        busy = 1'b0;
                        if (found) begin
                            req_ready[gnt] = 1'b1;
                            map_en         = 1'b1;
                            map_depth      = gnt_depth;
                            tag_d          = gnt;
                            ptr_d          = (gnt == ID_W'(NUM_ENGINES - 1)) ? '0 : gnt + ID_W'(1);
                        end
                    end
                end
                S_CALC: begin
                    if (div_done) begin
                        recip_d = RECIP_W'(div_quot);
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            init_q       <= 1'b1;
            ptr          <= '0;
            tag          <= '0;
            tag_live     <= 1'b0;
            map_max_iter <= '0;
            map_recip    <= '0;
        end else begin
            state        <= state_d;
            init_q       <= init_d;
            ptr          <= ptr_d;
            tag          <= tag_d;
            tag_live     <= map_en;
            map_max_iter <= max_iter_d;
            map_recip    <= recip_d;
        end
    end

    // Mapper has a fixed one-cycle latency, so a single tag register suffices
    assign out_valid  = map_valid & tag_live;
    assign out_color  = map_color;
    assign out_engine = tag;

`ifdef COLOR_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued <= '0;
            stat_stall  <= '0;
        end else begin
            if (map_en) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (busy && (|req_valid)) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/color_map_arbiter.md
Name: color_map_arbiter

Overview:
- Shares one table_color mapper between NUM_ENGINES Mandelbrot engines in the multiple-engine build.
- Round-robin grants one engine depth request per cycle to the mapper.
- Tags each issued request with its engine ID and returns the mapped colour with that tag.
- Owns max_iter_recip: a sequential divider recomputes floor(65536/max_iterations) whenever max_iterations changes. Grants stall while the divider runs.

Parameters:
- NUM_ENGINES, 4, number of requesting engines (2..16).
- ID_W, $clog2(NUM_ENGINES), width of the engine tag.
- RECIP_W, 16, reciprocal width (Q0.16).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- max_iterations  input  10  current iteration limit, quasi-static.
- req_valid  input  NUM_ENGINES  per-engine depth request valid.
- req_depth  input  NUM_ENGINES*10  packed depths; engine i at [10*i +: 10].
- req_ready  output  NUM_ENGINES  one-hot grant; transfer when valid&ready.
- map_en  output  1  to mapper en.
- map_depth  output  10  to mapper depth.
- map_max_iter  output  10  to mapper max_iterations; latched value used by the divider.
- map_recip  output  RECIP_W  to mapper max_iter_recip.
- map_valid  input  1  from mapper valid.
- map_color  input  24  from mapper color.
- out_valid  output  1  colour result valid; no backpressure.
- out_color  output  24  mapped colour.
- out_engine  output  ID_W  engine that issued the request.
- busy  output  1  high while the reciprocal is being recomputed.

Behaviour:
- Reset values:
  - req_ready=0, map_en=0, out_valid=0, busy=1.
  - map_recip=0, map_max_iter=0, RR pointer=0, tag register=0.
  - FSM enters CALC on the first cycle after reset deasserts.
- FSM states:
  - IDLE: grants are allowed.
    - If max_iterations != map_max_iter: latch the new value into map_max_iter, load the divider, go to CALC. No grant that cycle.
  - CALC: restoring division of 2^16 (17-bit dividend) by map_max_iter, one bit per cycle, 17 cycles.
    - On the final iteration write map_recip and go to IDLE.
    - busy=1 throughout CALC and on the IDLE cycle that detects a change.
- Quotient rules:
  - Divisor 0 gives 0.
  - Quotient > 16'hFFFF (divisor 1) saturates to 16'hFFFF.
  - map_recip holds its old value until the division completes.
- max_iterations changing again during CALC: the current division completes, then IDLE detects the mismatch and restarts.
- Arbitration, IDLE only, combinational within the cycle:
  - Grant g = first i with req_valid[i], searching from the RR pointer upward with wrap-around.
  - Outputs: req_ready[g]=1, map_en=1, map_depth=depth of g.
  - At the clock edge: pointer <= g+1 (mod NUM_ENGINES), tag <= g.
  - No valid requests: map_en=0 and pointer unchanged.
- Latency: the mapper registers at the end of grant cycle C, so map_valid rises in C+1.
  - out_valid = map_valid & tag_live, where tag_live is a 1-bit register set when map_en was high in the previous cycle.
  - out_color = map_color; out_engine = tag. Passthrough, zero added latency.
- Throughput: one request per cycle. Tag is a single register, valid because mapper latency is exactly 1.
- Reset mid-CALC: abort; state returns to reset values and CALC restarts after reset. A result in flight is dropped (tag_live=0).

Optional Feature:
- Macro COLOR_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_issued[31:0] (count of map_en cycles) and stat_stall[31:0] (cycles with any req_valid while busy).
  - Both zero on reset, wrap at 2^32.
- Undefined: no ports, no counters.

Decomposition:
- Package color_arb_pkg:
  - DEPTH_W=10, COLOR_W=24, RECIP_W default.
  - typedef enum {IDLE, CALC} arb_state_t.
  - Function computing the saturated reciprocal for bench reference.
- Sub-module recip_divider: start/done handshake, 17-cycle restoring divider with saturation. The arbiter instantiates one.

Test Plan:
- Reset, then max_iterations=100 → busy high for 17 cycles plus 1; map_recip=655 (0x028F); no req_ready during busy.
- All 4 engines valid continuously, max_iterations=100 → grants 0,1,2,3,0 in consecutive cycles; out_engine sequence lags grants by exactly 1 cycle.
- Only engines 1 and 3 valid, pointer=2 → grant 3 then 1; pointer wraps correctly.
- max_iterations changed 100→1 mid-stream → grants stop for 18 cycles; map_recip=16'hFFFF. max_iterations=0 → map_recip=0.
- Reset asserted during CALC cycle 8 → outputs return to reset values next cycle; fresh 17-cycle division follows.
- COLOR_ARB_STATS_EN defined, 10 grants plus 5 requested-while-busy cycles → stat_issued=10, stat_stall=5.
